// File: rtl/multicycle_ctrl.sv
// Multicycle Moore control FSM for the 16-bit RISC core: sequences FETCH..last state per instruction.
// Optional single-step WAIT state enabled by defining SINGLE_STEP_EN.
module multicycle_ctrl #(
    parameter int RESET_HOLD = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        test,
`ifdef SINGLE_STEP_EN
    input  logic        step,
`endif
    input  logic [15:0] opcode,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        Imm_5or8,
    output logic        RegWrite,
    output logic        OutREn,
    output logic        Branch,
    output logic        PSWEn,
    output logic        PCWrite,
    output logic        IorD,
    output logic        RegDst,
    output logic        LLorLH,
    output logic        ALUSrcA,
    output logic        JAorJR,
    output logic [1:0]  ALUop,
    output logic [1:0]  MemtoReg,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSrc,
    output logic [3:0]  state_o,
    output logic        instr_done,
    output logic        illegal
);

    typedef enum logic [3:0] {
        ST_INIT    = 4'd0,
        ST_FETCH   = 4'd1,
        ST_DECODE  = 4'd2,
        ST_EXEC    = 4'd3,
        ST_WB_ALU  = 4'd4,
        ST_WB_IMM  = 4'd5,
        ST_MEMRD   = 4'd6,
        ST_WB_MEM  = 4'd7,
        ST_MEMWR   = 4'd8,
        ST_BRANCH  = 4'd9,
        ST_JUMP    = 4'd10,
        ST_OUT     = 4'd11,
        ST_ILLEGAL = 4'd12,
        ST_WAIT    = 4'd13
    } state_t;

    typedef enum logic [3:0] {
        C_ALUR, C_LHI, C_LLI, C_LDR_IMM, C_LDR_REG, C_STR_IMM, C_STR_REG, C_CMP,
        C_ADDI, C_SUBI, C_MOV, C_JMP, C_JR, C_BCC, C_OUT, C_ILL
    } iclass_t;

    localparam logic [3:0] HOLD_LAST = 4'(RESET_HOLD - 1);

`ifdef SINGLE_STEP_EN
    localparam state_t AFTER_LAST = ST_WAIT;
`else
    localparam state_t AFTER_LAST = ST_FETCH;
`endif

    state_t      state_q, state_d;
    logic [3:0]  hold_cnt_q, hold_cnt_d;
    iclass_t     iclass;
    logic [4:0]  op;
    logic [1:0]  func;
    logic [1:0]  exec_srcb;
    logic [1:0]  exec_aluop;
    logic        dec_regdst;
    logic        step_rise;
    logic        unused_opcode_bits;

    assign op   = opcode[15:11];
    assign func = opcode[1:0];
    assign unused_opcode_bits = ^opcode[10:2];

`ifdef SINGLE_STEP_EN
    logic step_s1_q, step_s1_d, step_s2_q, step_s2_d, step_prev_q, step_prev_d;

    always_comb begin
        step_s1_d   = step;
        step_s2_d   = step_s1_q;
        step_prev_d = step_s2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_s1_q   <= 1'b0;
            step_s2_q   <= 1'b0;
            step_prev_q <= 1'b0;
        end else begin
            step_s1_q   <= step_s1_d;
            step_s2_q   <= step_s2_d;
            step_prev_q <= step_prev_d;
        end
    end

    assign step_rise = step_s2_q & ~step_prev_q;
`else
    assign step_rise = 1'b0;
`endif

    always_comb begin
        iclass = C_ILL;
        case (op)
            5'b00000: iclass = C_ALUR;
            5'b00001: iclass = C_LHI;
            5'b00010: iclass = C_LLI;
            5'b00011: iclass = C_LDR_IMM;
            5'b00100: iclass = C_LDR_REG;
            5'b00101: iclass = C_STR_IMM;
            5'b00110: iclass = (func == 2'b00) ? C_STR_REG :
                               (func == 2'b01) ? C_CMP : C_ILL;
            5'b00111: iclass = C_ADDI;
            5'b01000: iclass = C_SUBI;
            5'b01011: iclass = C_MOV;
            5'b10000: iclass = C_JMP;
            5'b10001: iclass = C_JR;
            5'b11000,
            5'b11001: iclass = C_BCC;
            5'b11100: iclass = C_OUT;
            default:  iclass = C_ILL;
        endcase
    end

    // Datapath selects set up in EXEC and held through the following memory/writeback state.
    always_comb begin
        exec_srcb  = 2'b00;
        exec_aluop = 2'b00;
        case (iclass)
            C_LDR_IMM, C_STR_IMM, C_ADDI: exec_srcb = 2'b10;
            C_SUBI: begin
                exec_srcb  = 2'b10;
                exec_aluop = 2'b10;
            end
            C_MOV:  exec_srcb  = 2'b11;
            C_ALUR: exec_aluop = func;
            C_CMP:  exec_aluop = 2'b10;
            default: ;
        endcase
        dec_regdst = (iclass == C_LHI) || (iclass == C_STR_IMM) || (iclass == C_STR_REG);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            hold_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_INIT: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = AFTER_LAST;
                    hold_cnt_d = 4'd0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end
            end
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                case (iclass)
                    C_LHI, C_LLI: state_d = ST_WB_IMM;
                    C_OUT:        state_d = ST_OUT;
                    C_BCC:        state_d = ST_BRANCH;
                    C_JMP, C_JR:  state_d = ST_JUMP;
                    C_ILL:        state_d = ST_ILLEGAL;
                    default:      state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                case (iclass)
                    C_LDR_IMM, C_LDR_REG: state_d = ST_MEMRD;
                    C_STR_IMM, C_STR_REG: state_d = ST_MEMWR;
                    C_CMP:                state_d = AFTER_LAST;
                    default:              state_d = ST_WB_ALU;
                endcase
            end
            ST_MEMRD: state_d = ST_WB_MEM;
            ST_WB_ALU, ST_WB_IMM, ST_WB_MEM, ST_MEMWR,
            ST_BRANCH, ST_JUMP, ST_OUT, ST_ILLEGAL: state_d = AFTER_LAST;
            ST_WAIT: if (step_rise) state_d = ST_FETCH;
            default: state_d = ST_INIT;
        endcase
        if (test) begin
            state_d    = ST_INIT;
            hold_cnt_d = 4'd0;
        end
    end

    always_comb begin
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        Imm_5or8   = 1'b0;
        RegWrite   = 1'b0;
        OutREn     = 1'b0;
        Branch     = 1'b0;
        PSWEn      = 1'b0;
        PCWrite    = 1'b0;
        IorD       = 1'b0;
        RegDst     = 1'b0;
        LLorLH     = 1'b0;
        ALUSrcA    = 1'b0;
        JAorJR     = 1'b0;
        ALUop      = 2'b00;
        MemtoReg   = 2'b00;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        instr_done = 1'b0;
        illegal    = 1'b0;
        state_o    = state_q;

        if (state_q inside {ST_EXEC, ST_WB_ALU, ST_MEMRD, ST_MEMWR}) begin
            ALUSrcA = 1'b1;
            ALUSrcB = exec_srcb;
            ALUop   = exec_aluop;
            RegDst  = dec_regdst;
        end

        case (state_q)
            ST_FETCH: begin
                ALUSrcB = 2'b01;
                PCWrite = 1'b1;
                IRWrite = 1'b1;
            end
            ST_DECODE: begin
                ALUSrcB  = 2'b10;
                Imm_5or8 = 1'b1;
                RegDst   = dec_regdst;
            end
            ST_EXEC: begin
                PSWEn      = (iclass == C_ALUR) || (iclass == C_CMP);
                instr_done = (iclass == C_CMP);
            end
            ST_WB_ALU: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            ST_WB_IMM: begin
                MemtoReg   = 2'b10;
                RegWrite   = 1'b1;
                LLorLH     = (iclass == C_LHI);
                RegDst     = (iclass == C_LHI);
                instr_done = 1'b1;
            end
            ST_MEMRD: IorD = 1'b1;
            ST_WB_MEM: begin
                IorD       = 1'b1;
                MemtoReg   = 2'b01;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            ST_MEMWR: begin
                IorD       = 1'b1;
                MemWrite   = 1'b1;
                instr_done = 1'b1;
            end
            ST_BRANCH: begin
                ALUSrcB    = 2'b10;
                Imm_5or8   = 1'b1;
                RegDst     = dec_regdst;
                PCSrc      = 2'b01;
                Branch     = 1'b1;
                instr_done = 1'b1;
            end
            ST_JUMP: begin
                PCSrc      = 2'b10;
                PCWrite    = 1'b1;
                JAorJR     = (iclass == C_JR);
                instr_done = 1'b1;
            end
            ST_OUT: begin
                OutREn     = 1'b1;
                instr_done = 1'b1;
            end
            ST_ILLEGAL: begin
                illegal    = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multicycle control FSM for the 16-bit RISC core. Sits directly upstream of the datapath and drives every datapath control input. It decodes the instruction-register value that the datapath exports on `opcode`. It replaces the hand-driven control sequences with a Moore state machine, one instruction per FETCH..last-state sequence.

Parameters:
- `RESET_HOLD`, 1: number of cycles spent in INIT after reset deassertion before the first FETCH (1..15).

Ports:
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `test` input 1: memory-load mode; while high the FSM is forced to INIT.
- `opcode` input 16: IR contents from the datapath. Fields: `op=[15:11]`, `func=[1:0]`.
- `MemWrite`, `IRWrite`, `Imm_5or8`, `RegWrite`, `OutREn`, `Branch`, `PSWEn`, `PCWrite`, `IorD`, `RegDst`, `LLorLH`, `ALUSrcA`, `JAorJR` output 1 each: datapath controls.
- `ALUop`, `MemtoReg`, `ALUSrcB`, `PCSrc` output 2 each: datapath controls.
- `state_o` output 4: current state encoding, for debug.
- `instr_done` output 1: high during the final state of each instruction.
- `illegal` output 1: high for one cycle in the ILLEGAL state.

Behaviour:
- **Reset.** Async reset forces state INIT. All outputs are 0 in INIT; `state_o` is 0.
- **Outputs.** All outputs are Moore-decoded from the state register plus `opcode`. No output is registered separately.
- **INIT.** Stays in INIT for `RESET_HOLD` cycles, then goes to FETCH. `test`=1 forces INIT from any state at the next edge and reloads the hold counter.
- **Opcode map:**
  - 00000 ALU-R: `ALUop`=`func` (00 ADD, 01 ADC, 10 SUB, 11 SBB)
  - 00001 LHI
  - 00010 LLI
  - 00011 LDR base+imm5
  - 00100 LDR base+reg
  - 00101 STR base+imm5
  - 00110 with `func`=00: STR base+reg
  - 00110 with `func`=01: CMP
  - 00111 ADDI
  - 01000 SUBI
  - 01011 MOV
  - 10000 JMP (absolute)
  - 10001 JR
  - 11000, 11001 Bcc
  - 11100 OUT
  - Everything else, including 00110 with `func`=1x, is illegal.
- **States and outputs.** Signals not listed are 0.
  - FETCH: `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUop`=00, `PCSrc`=00, `PCWrite`=1, `IRWrite`=1.
  - DECODE: `ALUSrcA`=0, `ALUSrcB`=10, `Imm_5or8`=1 (speculative branch target). `RegDst`=1 for LHI, STR, and STR-reg.
  - EXEC: `ALUSrcA`=1, `RegDst` held as in DECODE.
    - `ALUSrcB`=00 for ALU-R, CMP, LDR-reg and STR-reg.
    - `ALUSrcB`=10 with `Imm_5or8`=0 for imm-form LDR/STR, ADDI and SUBI.
    - `ALUSrcB`=11 for MOV.
    - `ALUop`: `func` for ALU-R; 10 for CMP and SUBI; 00 otherwise.
    - `PSWEn`=1 for ALU-R and CMP.
  - WB_ALU: EXEC datapath selects held, `MemtoReg`=00, `RegWrite`=1.
  - WB_IMM: `MemtoReg`=10, `RegWrite`=1, `LLorLH`=1 for LHI, `RegDst`=1 for LHI.
  - MEMRD: EXEC selects held, `IorD`=1.
  - WB_MEM: `IorD`=1, `MemtoReg`=01, `RegWrite`=1.
  - MEMWR: EXEC selects held, `IorD`=1, `MemWrite`=1.
  - BRANCH: DECODE selects held, `PCSrc`=01, `Branch`=1, `PCWrite`=0. The datapath qualifies the PC write with the condition.
  - JUMP: `PCSrc`=10, `PCWrite`=1, `JAorJR`=0 for JMP and 1 for JR.
  - OUT: `OutREn`=1.
  - ILLEGAL: `illegal`=1.
- **Sequences and cycle counts:**
  - LLI/LHI: F, D, WB_IMM (3)
  - OUT: F, D, OUT (3)
  - CMP: F, D, EXEC (3)
  - B: F, D, BRANCH (3)
  - JMP/JR: F, D, JUMP (3)
  - ALU-R/ADDI/SUBI/MOV: F, D, EXEC, WB_ALU (4)
  - STR: F, D, EXEC, MEMWR (4)
  - LDR: F, D, EXEC, MEMRD, WB_MEM (5)
  - Illegal: F, D, ILLEGAL (3)
- **Sequencing.** Every last state returns to FETCH. `instr_done`=1 in every last state, including ILLEGAL.
- **Decode timing.** The opcode is sampled in DECODE and later states only; IR is stable after FETCH. `opcode` value during FETCH is ignored.
- **Reset mid-instruction.** Goes to INIT immediately. A write strobe in progress is dropped that same instant.

Optional Feature:
- Macro: `SINGLE_STEP_EN`.
- Defined:
  - Adds input port `step` (1 bit) and a WAIT state entered instead of FETCH after every last state and after INIT.
  - WAIT drives all outputs 0 and advances to FETCH only on a rising edge of `step`, detected with a 2-flop synchronizer plus edge register.
  - `test` overrides WAIT.
- Undefined: no `step` port and no WAIT state; last states go straight to FETCH.

Test Plan:
- **Reset/INIT.** `rst_n`=0, then release with `RESET_HOLD`=1 → all outputs 0 during reset. First FETCH has `PCWrite`=1, `IRWrite`=1, `ALUSrcB`=01 one cycle after release.
- **LLI and LDR.** `opcode`=16'h1025 then 16'h1900 → LLI takes 3 cycles with `MemtoReg`=10 and `RegWrite`=1 in cycle 3. LDR takes 5 cycles with `IorD`=1 in cycles 4–5 and `MemtoReg`=01 in cycle 5.
- **ALU ops and CMP.** 16'h0328 (ADD), 16'h032A (SUB) and 16'h3029 (CMP) →
  - EXEC `ALUop` is 00, 10 and 10 respectively.
  - `PSWEn`=1 in EXEC for all three.
  - CMP has no `RegWrite` and returns to FETCH after 3 cycles.
- **Stores.** 16'h2C03 → `RegDst`=1 in DECODE, `MemWrite`=1 and `IorD`=1 in cycle 4. 16'h3328 → `ALUSrcB`=00 in EXEC.
- **Control flow.**
  - 16'hCE03 → BRANCH with `PCSrc`=01, `Branch`=1, `Imm_5or8`=1.
  - 16'h8035 → JUMP with `PCSrc`=10, `PCWrite`=1.
  - 16'hE000 → OUT with `OutREn`=1 in cycle 3.
- **Illegal, test override, step.**
  - 16'hF800 → `illegal` pulses one cycle in cycle 3.
  - `test`=1 asserted mid-LDR → INIT next edge with all outputs 0.
  - With `SINGLE_STEP_EN`, the FSM holds in WAIT until a `step` edge.
